// File: rtl/commit_trace_fifo.sv
// Commit-record FIFO between the retire point and the debug/difftest host.
// It adds backpressure, halt latching, a sticky overflow flag and a retired-instruction count.
module commit_trace_fifo #(
  parameter int DEPTH     = 8,
  parameter int XLEN      = 32,
  parameter int HALT_STOP = 1
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     global_en,
  input  logic                     flush,
  input  logic                     in_valid,
  output logic                     in_ready,
  input  logic [XLEN-1:0]          in_pc,
  input  logic [31:0]              in_inst,
  input  logic                     in_halt,
  input  logic                     in_reg_we,
  input  logic [4:0]               in_reg_wa,
  input  logic [XLEN-1:0]          in_reg_wd,
  input  logic                     in_dmem_we,
  input  logic [XLEN-1:0]          in_dmem_wa,
  input  logic [XLEN-1:0]          in_dmem_wd,
  output logic                     out_valid,
  input  logic                     out_ready,
  output logic [XLEN-1:0]          out_pc,
  output logic [31:0]              out_inst,
  output logic                     out_halt,
  output logic                     out_reg_we,
  output logic [4:0]               out_reg_wa,
  output logic [XLEN-1:0]          out_reg_wd,
  output logic                     out_dmem_we,
  output logic [XLEN-1:0]          out_dmem_wa,
  output logic [XLEN-1:0]          out_dmem_wd,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     halted,
  output logic                     overflow,
  output logic [31:0]              retired
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef struct packed {
    logic [XLEN-1:0] pc;
    logic [31:0]     inst;
    logic            halt;
    logic            reg_we;
    logic [4:0]      reg_wa;
    logic [XLEN-1:0] reg_wd;
    logic            dmem_we;
    logic [XLEN-1:0] dmem_wa;
    logic [XLEN-1:0] dmem_wd;
  } rec_t;

  rec_t            mem [DEPTH];
  rec_t            wr_rec;
  rec_t            head;
  logic [AW-1:0]   wr_ptr;
  logic [AW-1:0]   rd_ptr;
  logic [CW-1:0]   cnt;
  logic            halted_q;
  logic            overflow_q;
  logic [31:0]     retired_q;
  logic            push;
  logic            pop;

  // Ready depends on registered state only, so in_valid/out_ready never loop back.
  assign in_ready  = (cnt != FULL_CNT) && !((HALT_STOP != 0) && halted_q);
  assign out_valid = (cnt != '0);
  assign push      = in_valid && in_ready && global_en;
  assign pop       = out_valid && out_ready;

  assign wr_rec = '{pc: in_pc, inst: in_inst, halt: in_halt, reg_we: in_reg_we,
                    reg_wa: in_reg_wa, reg_wd: in_reg_wd, dmem_we: in_dmem_we,
                    dmem_wa: in_dmem_wa, dmem_wd: in_dmem_wd};

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
      retired_q  <= '0;
    end else if (flush) begin
      wr_ptr     <= '0;
      rd_ptr     <= '0;
      cnt        <= '0;
      halted_q   <= 1'b0;
      overflow_q <= 1'b0;
    end else begin
      if (push) begin
        wr_ptr    <= wr_ptr + AW'(1);
        retired_q <= retired_q + 32'd1;
        if (in_halt) halted_q <= 1'b1;
      end
      if (pop) rd_ptr <= rd_ptr + AW'(1);
      if (push && !pop)      cnt <= cnt + CW'(1);
      else if (pop && !push) cnt <= cnt - CW'(1);
      if (in_valid && global_en && !in_ready) overflow_q <= 1'b1;
    end
  end

  // Storage holds data only and is never reset.
  always_ff @(posedge clk) begin
    if (push && !flush) mem[wr_ptr] <= wr_rec;
  end

  // An empty buffer presents an all-zero record.
  assign head = out_valid ? mem[rd_ptr] : '0;

  assign out_pc      = head.pc;
  assign out_inst    = head.inst;
  assign out_halt    = head.halt;
  assign out_reg_we  = head.reg_we;
  assign out_reg_wa  = head.reg_wa;
  assign out_reg_wd  = head.reg_wd;
  assign out_dmem_we = head.dmem_we;
  assign out_dmem_wa = head.dmem_wa;
  assign out_dmem_wd = head.dmem_wd;
  assign count       = cnt;
  assign halted      = halted_q;
  assign overflow    = overflow_q;
  assign retired     = retired_q;

endmodule
